// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand bypass and RAW hazard stall; `FWD_EN selects bypass + 1-cycle load-use stall.
// Latency 1 cycle ID->EX; backpressure is the combinational stall that holds PC/IF-ID while a bubble enters EX.
module id_ex_operand_stage #(
  parameter int DW = 32,
  parameter int RW = 5,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [CW-1:0] id_alu_ctrl,
  input  logic          id_alu_src,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          id_mem_to_reg,
  input  logic          flush,
  input  logic          exm_reg_write,
  input  logic [RW-1:0] exm_rd,
  input  logic [DW-1:0] exm_alu_out,
  input  logic          mwb_reg_write,
  input  logic [RW-1:0] mwb_rd,
  input  logic [DW-1:0] mwb_data,
  output logic          stall,
  output logic          ex_valid,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [CW-1:0] alu_ctrl,
  output logic [DW-1:0] ex_store_data,
  output logic [RW-1:0] ex_rd,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_mem_to_reg
);

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] rd;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic [CW-1:0] alu_ctrl;
    logic          alu_src;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          mem_to_reg;
  } ex_t;

  ex_t ex_q, ex_d;
  logic hazard;
  logic bubble;
  logic [DW-1:0] fwd_rs, fwd_rt;

`ifdef FWD_EN
  logic ex_rd_hit;

  // Only a load in EX can't be bypassed; one bubble lets it reach MEM/WB.
  always_comb begin
    ex_rd_hit = (ex_q.rd != '0) && ((ex_q.rd == id_rs) || (ex_q.rd == id_rt));
    hazard    = id_valid && ex_q.valid && ex_q.mem_read && ex_rd_hit;
  end

  function automatic logic [DW-1:0] bypass(input logic [RW-1:0] src,
                                           input logic [DW-1:0] reg_val);
    if (exm_reg_write && (exm_rd != '0) && (exm_rd == src))
      return exm_alu_out;
    else if (mwb_reg_write && (mwb_rd != '0) && (mwb_rd == src))
      return mwb_data;
    else
      return reg_val;
  endfunction

  always_comb begin
    fwd_rs = bypass(ex_q.rs, ex_q.rs_data);
    fwd_rt = bypass(ex_q.rt, ex_q.rt_data);
  end
`else
  logic rs_dep, rt_dep;
  logic unused_mwb;

  // Without bypass, wait until the producer has left EX/MEM; the register
  // file covers the MEM/WB write by writing before reading.
  always_comb begin
    rs_dep = (id_rs != '0) &&
             ((ex_q.valid && ex_q.reg_write && (ex_q.rd == id_rs)) ||
              (exm_reg_write && (exm_rd == id_rs)));
    rt_dep = (id_rt != '0) &&
             ((ex_q.valid && ex_q.reg_write && (ex_q.rd == id_rt)) ||
              (exm_reg_write && (exm_rd == id_rt)));
    hazard = id_valid && (rs_dep || rt_dep);
  end

  always_comb begin
    fwd_rs = ex_q.rs_data;
    fwd_rt = ex_q.rt_data;
  end

  assign unused_mwb = ^{exm_alu_out, mwb_reg_write, mwb_rd, mwb_data, ex_q.rs, ex_q.rt};
`endif

  assign stall  = hazard && !flush && !reset;
  assign bubble = flush || stall || !id_valid;

  // Data fields load every cycle; a bubble only clears valid and side-effect controls.
  always_comb begin
    ex_d.valid      = id_valid;
    ex_d.rs         = id_rs;
    ex_d.rt         = id_rt;
    ex_d.rd         = id_rd;
    ex_d.rs_data    = id_rs_data;
    ex_d.rt_data    = id_rt_data;
    ex_d.imm        = id_imm;
    ex_d.alu_ctrl   = id_alu_ctrl;
    ex_d.alu_src    = id_alu_src;
    ex_d.reg_write  = id_reg_write;
    ex_d.mem_read   = id_mem_read;
    ex_d.mem_write  = id_mem_write;
    ex_d.mem_to_reg = id_mem_to_reg;
    if (bubble) begin
      ex_d.valid      = 1'b0;
      ex_d.reg_write  = 1'b0;
      ex_d.mem_read   = 1'b0;
      ex_d.mem_write  = 1'b0;
      ex_d.mem_to_reg = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ex_q <= '0;
    else       ex_q <= ex_d;
  end

  assign ex_valid      = ex_q.valid;
  assign alu_a         = fwd_rs;
  assign alu_b         = ex_q.alu_src ? ex_q.imm : fwd_rt;
  assign alu_ctrl      = ex_q.alu_ctrl;
  assign ex_store_data = fwd_rt;
  assign ex_rd         = ex_q.rd;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_mem_to_reg = ex_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: vector table plus hazard/bypass/reset sequences.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [3:0]  id_alu_ctrl;
  logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        flush;
  logic        exm_reg_write;
  logic [4:0]  exm_rd;
  logic [31:0] exm_alu_out;
  logic        mwb_reg_write;
  logic [4:0]  mwb_rd;
  logic [31:0] mwb_data;
  logic        stall, ex_valid;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [3:0]  alu_ctrl;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_alu_ctrl(id_alu_ctrl), .id_alu_src(id_alu_src),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .flush(flush),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_alu_out(exm_alu_out),
    .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
    .stall(stall), .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ctrl(alu_ctrl), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
  );

  typedef struct {
    logic        vld;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rsd, rtd, imm;
    logic [3:0]  ctrl;
    logic        src;
    logic [3:0]  cb;      // {reg_write, mem_read, mem_write, mem_to_reg}
    logic        flush;
    logic        e_stall;
    logic        e_vld;
    logic [31:0] e_a, e_b, e_st;
    logic [3:0]  e_ctrl;
    logic [4:0]  e_rd;
    logic [3:0]  e_cb;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                        input logic [31:0] imm, input logic [3:0] ctrl, input logic src,
                        input logic [3:0] cb);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    id_alu_ctrl = ctrl; id_alu_src = src;
    {id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg} = cb;
  endtask

  task automatic clr_fwd();
    exm_reg_write = 1'b0; exm_rd = 5'd0; exm_alu_out = 32'h0;
    mwb_reg_write = 1'b0; mwb_rd = 5'd0; mwb_data = 32'h0;
  endtask

  function automatic logic [31:0] cbits();
    return 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg});
  endfunction

  initial begin
    vt[0] = '{1'b1, 5'd1, 5'd2, 5'd3, 32'hAAAA0001, 32'h55550002, 32'h10, 4'h2, 1'b0, 4'b1000, 1'b0,
              1'b0, 1'b1, 32'hAAAA0001, 32'h55550002, 32'h55550002, 4'h2, 5'd3, 4'b1000};
    vt[1] = '{1'b1, 5'd4, 5'd5, 5'd6, 32'h100, 32'h200, 32'hFFFFFFF0, 4'hA, 1'b1, 4'b1101, 1'b0,
              1'b0, 1'b1, 32'h100, 32'hFFFFFFF0, 32'h200, 4'hA, 5'd6, 4'b1101};
    vt[2] = '{1'b0, 5'd7, 5'd8, 5'd9, 32'h77, 32'h88, 32'h0, 4'h5, 1'b0, 4'b1010, 1'b0,
              1'b0, 1'b0, 32'h77, 32'h88, 32'h88, 4'h5, 5'd9, 4'b0000};
    vt[3] = '{1'b1, 5'd9, 5'd10, 5'd0, 32'h99, 32'h1010, 32'h8, 4'h3, 1'b1, 4'b0010, 1'b1,
              1'b0, 1'b0, 32'h99, 32'h8, 32'h1010, 4'h3, 5'd0, 4'b0000};
    vt[4] = '{1'b1, 5'd11, 5'd12, 5'd0, 32'h1000, 32'hDEADBEEF, 32'h4, 4'h2, 1'b1, 4'b0010, 1'b0,
              1'b0, 1'b1, 32'h1000, 32'h4, 32'hDEADBEEF, 4'h2, 5'd0, 4'b0010};
    vt[5] = '{1'b1, 5'd0, 5'd14, 5'd13, 32'h0, 32'h80000001, 32'h0, 4'hF, 1'b0, 4'b1000, 1'b0,
              1'b0, 1'b1, 32'h0, 32'h80000001, 32'h80000001, 4'hF, 5'd13, 4'b1000};

    // Reset held two cycles with a live instruction presented.
    reset = 1'b1; flush = 1'b0; clr_fwd();
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'h1234, 32'h5678, 32'h9, 4'h7, 1'b0, 4'b1111);
    tick(); tick();
    chk("rst_ex_valid", 32'(ex_valid), 32'h0);
    chk("rst_alu_a", alu_a, 32'h0);
    chk("rst_alu_b", alu_b, 32'h0);
    chk("rst_alu_ctrl", 32'(alu_ctrl), 32'h0);
    chk("rst_ctrl_bits", cbits(), 32'h0);
    chk("rst_ex_rd", 32'(ex_rd), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      set_id(vt[i].vld, vt[i].rs, vt[i].rt, vt[i].rd, vt[i].rsd, vt[i].rtd, vt[i].imm,
             vt[i].ctrl, vt[i].src, vt[i].cb);
      flush = vt[i].flush;
      #3;
      chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vt[i].e_stall));
      tick();
      chk($sformatf("v%0d_ex_valid", i), 32'(ex_valid), 32'(vt[i].e_vld));
      chk($sformatf("v%0d_alu_a", i), alu_a, vt[i].e_a);
      chk($sformatf("v%0d_alu_b", i), alu_b, vt[i].e_b);
      chk($sformatf("v%0d_store", i), ex_store_data, vt[i].e_st);
      chk($sformatf("v%0d_alu_ctrl", i), 32'(alu_ctrl), 32'(vt[i].e_ctrl));
      chk($sformatf("v%0d_ex_rd", i), 32'(ex_rd), 32'(vt[i].e_rd));
      chk($sformatf("v%0d_ctrl_bits", i), cbits(), 32'(vt[i].e_cb));
    end
    flush = 1'b0;

    // Load r5 followed by a consumer of r5.
    set_id(1'b1, 5'd1, 5'd5, 5'd5, 32'h40, 32'h0, 32'h0, 4'h2, 1'b1, 4'b1101);
    tick();
    set_id(1'b1, 5'd5, 5'd6, 5'd7, 32'h0BAD, 32'h6, 32'h0, 4'h2, 1'b0, 4'b1000);
    #3;
    chk("lu_stall", 32'(stall), 32'h1);
    tick();
    chk("lu_bubble_valid", 32'(ex_valid), 32'h0);
    chk("lu_bubble_rw", 32'(ex_reg_write), 32'h0);
    exm_reg_write = 1'b1; exm_rd = 5'd5; exm_alu_out = 32'h40;
`ifdef FWD_EN
    #3;
    chk("lu_stall_once", 32'(stall), 32'h0);
    tick();
    exm_reg_write = 1'b0;
    mwb_reg_write = 1'b1; mwb_rd = 5'd5; mwb_data = 32'hCAFE;
    #1;
    chk("lu_fwd_valid", 32'(ex_valid), 32'h1);
    chk("lu_fwd_alu_a", alu_a, 32'hCAFE);
    chk("lu_fwd_alu_b", alu_b, 32'h6);
`else
    #3;
    chk("raw_stall_exm", 32'(stall), 32'h1);
    tick();
    chk("raw_bubble2", 32'(ex_valid), 32'h0);
    exm_reg_write = 1'b0;
    mwb_reg_write = 1'b1; mwb_rd = 5'd5; mwb_data = 32'hCAFE;
    id_rs_data = 32'hCAFE;
    #3;
    chk("raw_stall_clear", 32'(stall), 32'h0);
    tick();
    chk("raw_valid", 32'(ex_valid), 32'h1);
    chk("raw_alu_a", alu_a, 32'hCAFE);
`endif
    clr_fwd();

    // Flush overrides a pending load-use stall.
    set_id(1'b1, 5'd1, 5'd5, 5'd5, 32'h40, 32'h0, 32'h0, 4'h2, 1'b1, 4'b1101);
    tick();
    set_id(1'b1, 5'd5, 5'd6, 5'd0, 32'h50, 32'h60, 32'h0, 4'h2, 1'b1, 4'b0010);
    flush = 1'b1;
    #3;
    chk("flush_stall", 32'(stall), 32'h0);
    tick();
    flush = 1'b0;
    chk("flush_ex_valid", 32'(ex_valid), 32'h0);
    chk("flush_mem_write", 32'(ex_mem_write), 32'h0);

    // EX/MEM beats MEM/WB; otherwise the registered value is used.
    set_id(1'b1, 5'd3, 5'd3, 5'd8, 32'h33, 32'h34, 32'h0, 4'h2, 1'b0, 4'b1000);
    tick();
    exm_reg_write = 1'b1; exm_rd = 5'd3; exm_alu_out = 32'h11;
    mwb_reg_write = 1'b1; mwb_rd = 5'd3; mwb_data = 32'h22;
    #1;
`ifdef FWD_EN
    chk("byp_exm_a", alu_a, 32'h11);
    chk("byp_exm_b", alu_b, 32'h11);
    chk("byp_exm_st", ex_store_data, 32'h11);
    exm_reg_write = 1'b0;
    #1;
    chk("byp_mwb_a", alu_a, 32'h22);
`else
    chk("nobyp_a", alu_a, 32'h33);
    chk("nobyp_b", alu_b, 32'h34);
    chk("nobyp_st", ex_store_data, 32'h34);
    exm_reg_write = 1'b0;
    #1;
    chk("nobyp_mwb_a", alu_a, 32'h33);
`endif
    mwb_reg_write = 1'b0;
    #1;
    chk("byp_none_a", alu_a, 32'h33);
    clr_fwd();

    // Register 0 is never bypassed nor a hazard source.
    set_id(1'b1, 5'd0, 5'd0, 5'd8, 32'h0, 32'h0, 32'h0, 4'h2, 1'b0, 4'b1000);
    tick();
    exm_reg_write = 1'b1; exm_rd = 5'd0; exm_alu_out = 32'h99;
    mwb_reg_write = 1'b1; mwb_rd = 5'd0; mwb_data = 32'h77;
    #1;
    chk("r0_alu_a", alu_a, 32'h0);
    chk("r0_alu_b", alu_b, 32'h0);
    set_id(1'b1, 5'd0, 5'd0, 5'd9, 32'h0, 32'h0, 32'h0, 4'h2, 1'b0, 4'b1000);
    #1;
    chk("r0_stall", 32'(stall), 32'h0);
    tick();
    clr_fwd();

    // Reset mid-stream discards the EX instruction and masks stall.
    set_id(1'b1, 5'd1, 5'd5, 5'd5, 32'h40, 32'h0, 32'h0, 4'h2, 1'b1, 4'b1101);
    tick();
    set_id(1'b1, 5'd5, 5'd6, 5'd7, 32'h1, 32'h2, 32'h0, 4'h2, 1'b0, 4'b1000);
    reset = 1'b1;
    #3;
    chk("midrst_stall", 32'(stall), 32'h0);
    tick();
    chk("midrst_ex_valid", 32'(ex_valid), 32'h0);
    chk("midrst_alu_a", alu_a, 32'h0);
    chk("midrst_ctrl_bits", cbits(), 32'h0);
    reset = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
